// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the
// instruction-fetch path (IF) and the load/store data path (D).
// One transaction at a time: IDLE arbitrates, ISSUE drives the memory for
// one cycle, WAIT counts out the fixed read latency (reads only).
// Conflicts go to D unless IF has lost MAX_WAIT times in a row.
// Build option: define ARB_RR_EN for round-robin conflict resolution
// (no age counter; D wins the first conflict after reset).
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   if_req/if_addr                   IF read request
//   if_gnt/if_rvalid/if_rdata        IF issue strobe, read-data pulse, data
//   d_req/d_we/d_addr/d_wdata        data request (d_we=1 store)
//   d_gnt/d_rvalid/d_rdata           data issue strobe, load pulse, data
//   mem_en/mem_we/mem_addr/mem_wdata memory strobe and payload (0 outside ISSUE)
//   mem_rdata                        memory read data, RD_LAT after mem_en
//   busy                             high whenever not IDLE
module mem_port_arbiter #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CW    = 3;
  localparam int unsigned AGE_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          owner_if, owner_if_n;
  logic          win_if;

  logic          if_gnt_n, d_gnt_n, if_rvalid_n, d_rvalid_n;
  logic          mem_en_n, mem_we_n, busy_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n, if_rdata_n, d_rdata_n;

`ifdef ARB_RR_EN
  // Remembers whether IF received the most recent grant.
  logic last_if, last_if_n;

  // Conflict winner: whoever was not granted last.
  always_comb begin
    win_if = if_req & (~d_req | ~last_if);
  end
`else
  // Consecutive IF arbitration losses, saturating.
  logic [AGE_W-1:0] age, age_n;

  // Conflict winner: D, unless IF has waited long enough.
  always_comb begin
    win_if = if_req & (~d_req | (age >= AGE_W'(MAX_WAIT)));
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    owner_if_n  = owner_if;
    if_gnt_n    = 1'b0;
    d_gnt_n     = 1'b0;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = '0;
    mem_wdata_n = '0;
    if_rvalid_n = 1'b0;
    d_rvalid_n  = 1'b0;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
`ifdef ARB_RR_EN
    last_if_n   = last_if;
`else
    age_n       = age;
`endif

    case (state)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_n    = S_ISSUE;
          owner_if_n = win_if;
          mem_en_n   = 1'b1;
          if (win_if) begin
            if_gnt_n   = 1'b1;
            mem_addr_n = if_addr;
          end else begin
            d_gnt_n     = 1'b1;
            mem_we_n    = d_we;
            mem_addr_n  = d_addr;
            mem_wdata_n = d_wdata;
          end
`ifdef ARB_RR_EN
          last_if_n = win_if;
`else
          if (win_if) begin
            age_n = '0;
          end else if (if_req && (age != {AGE_W{1'b1}})) begin
            age_n = age + AGE_W'(1);
          end
`endif
        end
      end
      S_ISSUE: begin
        // mem_we still holds the issued direction during ISSUE.
        if (mem_we) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_WAIT;
          cnt_n   = CW'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
          if (owner_if) begin
            if_rdata_n  = mem_rdata;
            if_rvalid_n = 1'b1;
          end else begin
            d_rdata_n  = mem_rdata;
            d_rvalid_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      owner_if  <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
`ifdef ARB_RR_EN
      last_if   <= 1'b1;
`else
      age       <= '0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      owner_if  <= owner_if_n;
      if_gnt    <= if_gnt_n;
      d_gnt     <= d_gnt_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if_rvalid <= if_rvalid_n;
      d_rvalid  <= d_rvalid_n;
      if_rdata  <= if_rdata_n;
      d_rdata   <= d_rdata_n;
      busy      <= busy_n;
`ifdef ARB_RR_EN
      last_if   <= last_if_n;
`else
      age       <= age_n;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW       = 16;
  localparam int unsigned DW       = 16;
  localparam int unsigned RD_LAT   = 3;
  localparam int unsigned MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(int a);
    if (a == 16) return 16'hA5A5;
    return 16'((a << 8) | (255 - a));
  endfunction

  // Memory macro: fixed RD_LAT read pipeline, garbage when no read is due.
  bit [15:0] mem_data [256];
  bit        mem_wr   [256];
  bit [15:0] pipe     [RD_LAT];
  logic [7:0] ma;
  assign ma = mem_addr[7:0];
  assign mem_rdata = pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (mem_en && !mem_we) pipe[0] <= mem_wr[ma] ? mem_data[ma] : init_val(int'(ma));
    else                   pipe[0] <= 16'($urandom);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    if (mem_en && mem_we) begin
      mem_data[ma] <= mem_wdata;
      mem_wr[ma]   <= 1'b1;
    end
  end

  // Reference model: transactions scheduled on an absolute cycle timeline.
  int          mcyc = 0, idle_from = 0, g_cyc = -100, rv_cyc = -100, age = 0;
  bit          last_if = 1'b1, g_if = 1'b0, g_we = 1'b0, rv_if = 1'b0, win;
  logic [15:0] g_addr = '0, g_wdata = '0, rv_data = '0;
  bit   [15:0] ref_mem [256];
  logic [6:0]  exp_ctl = '0;
  logic [15:0] exp_addr = '0, exp_wdata = '0, exp_if_rdata = '0, exp_d_rdata = '0;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mcyc = 0; idle_from = 0; g_cyc = -100; rv_cyc = -100; age = 0; last_if = 1'b1;
        exp_ctl = '0; exp_addr = '0; exp_wdata = '0; exp_if_rdata = '0; exp_d_rdata = '0;
      end else begin
        mcyc++;
        if ((mcyc - 1 >= idle_from) && (if_req === 1'b1 || d_req === 1'b1)) begin
`ifdef ARB_RR_EN
          win = if_req && (!d_req || !last_if);
          last_if = win;
`else
          win = if_req && (!d_req || age >= int'(MAX_WAIT));
          if (win) age = 0;
          else if (if_req) age = (age < 15) ? age + 1 : 15;
`endif
          g_cyc = mcyc; g_if = win;
          g_we    = win ? 1'b0 : d_we;
          g_addr  = win ? if_addr : d_addr;
          g_wdata = win ? 16'h0 : d_wdata;
          if (g_we) begin
            ref_mem[g_addr[7:0]] = g_wdata;
            idle_from = mcyc + 1;
          end else begin
            rv_cyc = mcyc + int'(RD_LAT) + 1;
            rv_if = win;
            rv_data = ref_mem[g_addr[7:0]];
            idle_from = rv_cyc;
          end
        end
        exp_ctl = {(mcyc == g_cyc) && g_if, (mcyc == g_cyc) && !g_if, mcyc == g_cyc,
                   (mcyc == g_cyc) && g_we, (mcyc >= g_cyc) && (mcyc < idle_from),
                   (mcyc == rv_cyc) && rv_if, (mcyc == rv_cyc) && !rv_if};
        exp_addr  = (mcyc == g_cyc) ? g_addr : 16'h0;
        exp_wdata = (mcyc == g_cyc) ? g_wdata : 16'h0;
        if (mcyc == rv_cyc) begin
          if (rv_if) exp_if_rdata = rv_data;
          else       exp_d_rdata  = rv_data;
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0 ||
        mem_addr !== 16'h0 || mem_wdata !== 16'h0 || if_rdata !== 16'h0 || d_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ctl=%b addr=%h wdata=%h ifd=%h dd=%h, expected all 0",
               {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}, mem_addr, mem_wdata,
               if_rdata, d_rdata);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_if_read(input string nm);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0010;
    for (int k = 1; k <= int'(RD_LAT) + 3; k++) begin
      @(posedge clk); #1;
      if (k == 2) if_req = 1'b0;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'(k == 1) || mem_en !== 1'(k == 1) || mem_addr !== ((k == 1) ? 16'h0010 : 16'h0)) begin
        errors++;
        $display("FAIL %s_issue k=%0d: got gnt=%b en=%b addr=%h, expected gnt/en=%b", nm, k,
                 if_gnt, mem_en, mem_addr, 1'(k == 1));
      end
      checks++;
      if (if_rvalid !== 1'(k == int'(RD_LAT) + 2) || ((k == int'(RD_LAT) + 2) && if_rdata !== 16'hA5A5)) begin
        errors++;
        $display("FAIL %s_rvalid k=%0d: got rvalid=%b rdata=%h, expected rdata A5A5 at k=%0d", nm, k,
                 if_rvalid, if_rdata, RD_LAT + 2);
      end
    end
  endtask

  task automatic test_store_load();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 2) d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'(k == 1) || mem_we !== 1'(k == 1) ||
          mem_wdata !== ((k == 1) ? 16'h1234 : 16'h0) || d_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL store k=%0d: got gnt=%b we=%b wdata=%h rvalid=%b", k, d_gnt, mem_we, mem_wdata, d_rvalid);
      end
      if (k == 2) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL store_busy: got %b expected 0", busy);
        end
      end
    end
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020; d_wdata = 16'h0;
    for (int k = 1; k <= int'(RD_LAT) + 3; k++) begin
      @(posedge clk); #1;
      if (k == 2) d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'(k == 1) || d_rvalid !== 1'(k == int'(RD_LAT) + 2) ||
          ((k == int'(RD_LAT) + 2) && d_rdata !== 16'h1234)) begin
        errors++;
        $display("FAIL load k=%0d: got gnt=%b rvalid=%b rdata=%h, expected data 1234 at k=%0d",
                 k, d_gnt, d_rvalid, d_rdata, RD_LAT + 2);
      end
    end
  endtask

  task automatic test_conflict();
    int n = 0;
    int target = 2 * (int'(MAX_WAIT) + 1);
    bit exp_if;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0011; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0021;
    for (int c = 0; c < 200 && n < target; c++) begin
      @(negedge clk);
      checks++;
      if (if_gnt === 1'b1 && d_gnt === 1'b1) begin
        errors++;
        $display("FAIL conflict_onehot: got if_gnt=1 d_gnt=1 expected at most one");
      end
      if (if_gnt === 1'b1 || d_gnt === 1'b1) begin
`ifdef ARB_RR_EN
        exp_if = (n % 2) == 1;
`else
        exp_if = (n % (int'(MAX_WAIT) + 1)) == int'(MAX_WAIT);
`endif
        checks++;
        if (if_gnt !== exp_if) begin
          errors++;
          $display("FAIL conflict_grant n=%0d: got if_gnt=%b expected %b", n, if_gnt, exp_if);
        end
        n++;
      end
    end
    checks++;
    if (n != target) begin
      errors++;
      $display("FAIL conflict_timeout: got %0d grants expected %0d", n, target);
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    repeat (int'(RD_LAT) + 3) @(posedge clk);
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0010;
    @(posedge clk); #1;            // gnt cycle
    @(posedge clk); #1;            // first WAIT cycle
    if_req = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0 ||
        mem_addr !== 16'h0 || if_rdata !== 16'h0 || d_rdata !== 16'h0) begin
      errors++;
      $display("FAIL midread_reset: got ctl=%b addr=%h ifd=%h dd=%h expected all 0",
               {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}, mem_addr, if_rdata, d_rdata);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < int'(RD_LAT) + 3; k++) begin
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midread_quiet k=%0d: got ifv=%b dv=%b busy=%b expected 0", k, if_rvalid, d_rvalid, busy);
      end
    end
    test_if_read("after_reset");
  endtask

  task automatic test_back_to_back();
    int rv_at = -1, g_at = -1;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        d_req = 1'b0; if_req = 1'b1; if_addr = 16'h0030;
      end
      if (g_at >= 0 && k == g_at + 1) if_req = 1'b0;
      @(negedge clk);
      if (d_rvalid === 1'b1 && rv_at < 0) begin
        rv_at = k;
        checks++;
        if (d_rdata !== 16'h1234) begin
          errors++;
          $display("FAIL b2b_data: got %h expected 1234", d_rdata);
        end
      end
      if (if_gnt === 1'b1 && g_at < 0) g_at = k;
    end
    checks++;
    if (rv_at != int'(RD_LAT) + 2 || g_at != rv_at + 1) begin
      errors++;
      $display("FAIL b2b_timing: got rvalid at %0d if_gnt at %0d, expected %0d and %0d",
               rv_at, g_at, RD_LAT + 2, RD_LAT + 3);
    end
    repeat (int'(RD_LAT) + 3) @(posedge clk);
  endtask

  task automatic test_random();
    bit if_seen = 1'b0, d_seen = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (!if_req || if_seen) begin
        if_req  = ($urandom % 3) != 0;
        if_addr = 16'($urandom_range(0, 63));
      end
      if (!d_req || d_seen) begin
        d_req   = ($urandom % 3) != 0;
        d_we    = 1'($urandom % 2);
        d_addr  = 16'($urandom_range(0, 63));
        d_wdata = 16'($urandom);
      end
      if_seen = 1'b0; d_seen = 1'b0;
      @(negedge clk);
      if (if_gnt === 1'b1) if_seen = 1'b1;
      if (d_gnt === 1'b1)  d_seen  = 1'b1;
      checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we, busy, if_rvalid, d_rvalid} !== exp_ctl) begin
        errors++;
        $display("FAIL rand_ctl c=%0d: got %b expected %b", c,
                 {if_gnt, d_gnt, mem_en, mem_we, busy, if_rvalid, d_rvalid}, exp_ctl);
      end
      checks++;
      if (mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
        errors++;
        $display("FAIL rand_mem c=%0d: got addr=%h wdata=%h expected %h %h", c, mem_addr, mem_wdata,
                 exp_addr, exp_wdata);
      end
      checks++;
      if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
        errors++;
        $display("FAIL rand_rdata c=%0d: got if=%h d=%h expected %h %h", c, if_rdata, d_rdata,
                 exp_if_rdata, exp_d_rdata);
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    repeat (int'(RD_LAT) + 3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_if_read("single_read");
    test_store_load();
    test_conflict();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16-bit unified memory between two requesters: the instruction-fetch path (IF) and the load/store data path (D).
- Sits between the control unit and the memory macro.
- Serialises one transaction at a time and handles the fixed memory read latency.
- Arbitrates conflicts by data priority with an anti-starvation age counter for IF.

Parameters:
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal 1..8
- MAX_WAIT, 4, consecutive IF arbitration losses after which IF wins the next conflict; legal 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  IF read request
- if_addr  in  AW  IF read address
- if_gnt  out  1  IF transaction issued this cycle
- if_rvalid  out  1  IF read data valid, one-cycle pulse
- if_rdata  out  DW  IF read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  data transaction issued this cycle
- d_rvalid  out  1  load data valid, one-cycle pulse
- d_rdata  out  DW  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low on reset_n.
- Reset values: state = IDLE; all outputs 0; age counter 0; any in-flight transaction is dropped and no rvalid is produced.
- States:
  - IDLE: arbitrate.
  - ISSUE: drive memory for one cycle.
  - WAIT: count RD_LAT cycles, reads only.
- IDLE:
  - If any req is high, latch the winner's addr/we/wdata and owner tag at the clock edge, then go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration in IDLE:
  - Only one requester high: that requester wins.
  - Both high: D wins unless age >= MAX_WAIT, in which case IF wins.
  - Age increments (saturating at 15) each time IF requests and loses; it clears when IF is granted.
- ISSUE, cycle T:
  - mem_en=1; mem_addr, mem_we, mem_wdata come from the latched values.
  - Owner's gnt=1 for exactly this cycle.
  - Store: go to IDLE at T+1; no rvalid.
  - Load or IF read: go to WAIT.
- WAIT:
  - Down-counter loaded with RD_LAT-1 on entry.
  - When the counter is 0 (cycle T+RD_LAT), capture mem_rdata into the owner's rdata register; set the owner's rvalid for the next cycle; go to IDLE.
- Latency:
  - Request seen in IDLE at cycle T-1 → gnt at T.
  - Read rvalid/rdata at T+RD_LAT+1; minimum request-to-data is RD_LAT+2 cycles.
  - rvalid is concurrent with IDLE, so a new arbitration can happen in the same cycle.
- Outputs:
  - mem_en, mem_we, mem_addr and mem_wdata are 0 outside ISSUE.
  - rdata holds its value until the next capture for the same requester.
- Requester rules:
  - The requester holds req/addr/wdata until it sees gnt, and deasserts req in the cycle after gnt unless it wants another transfer.
  - req still high in IDLE is treated as a new request.
  - req dropped after the IDLE sampling edge does not cancel the transaction.
- Requests arriving while busy are ignored until IDLE.
- At most one gnt and at most one rvalid per cycle; if_gnt and d_gnt are never both high.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: conflicts resolve round-robin. The requester not granted last wins, starting with D after reset. The age counter and MAX_WAIT are unused, and age logic is removed.
- Undefined: data priority with MAX_WAIT aging, as described above.

Test Plan:
- Single IF read, RD_LAT=1:
  - Stimulus: if_req at cycle 0, if_addr=0x0010, memory[0x0010]=0xA5A5.
  - Response: if_gnt at cycle 1 with mem_en=1 and mem_addr=0x0010; if_rvalid=1 with if_rdata=0xA5A5 at cycle 3.
- Store:
  - Stimulus: d_req, d_we=1, d_addr=0x0020, d_wdata=0x1234.
  - Response: d_gnt with mem_we=1 and mem_wdata=0x1234 for one cycle; no d_rvalid; busy low the next cycle.
  - Then load 0x0020 with RD_LAT=3: d_rdata=0x1234 four cycles after d_gnt.
- Conflict:
  - Stimulus: if_req and d_req both held continuously with MAX_WAIT=4.
  - Response: D granted 4 times, then IF once, repeating; the pattern stays fixed and the age counter clears on each IF grant.
- ARB_RR_EN build, same stimulus:
  - Response: grants alternate D, IF, D, IF.
- Reset mid-read:
  - Stimulus: assert reset_n=0 during WAIT, RD_LAT=4.
  - Response: all outputs 0 immediately; no rvalid after release; the next if_req is served normally.
- Back-to-back:
  - Stimulus: d_req read completes; if_req already pending.
  - Response: if_gnt occurs exactly one cycle after the cycle in which d_rvalid pulses.
